// File: rtl/aes256_dec_sched_if.sv
// Handshake bundle for the AES-256 decryption sequencer: key load, ciphertext in, plaintext out.
// Every channel is valid/ready: a transfer happens on a rising edge where both are high; the
// source holds payload and valid stable until that edge, and ready may depend on valid.
interface aes256_dec_sched_if;
  logic [255:0] key;
  logic         key_valid;
  logic         key_ready;
  logic [127:0] din;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] dout;
  logic         out_valid;
  logic         out_ready;

  modport master (
    output key, key_valid, din, in_valid, out_ready,
    input  key_ready, in_ready, dout, out_valid
  );

  modport slave (
    input  key, key_valid, din, in_valid, out_ready,
    output key_ready, in_ready, dout, out_valid
  );
endinterface

// File: rtl/aes256_dec_sched.sv
// Iterative AES-256 decryption sequencer driving one external inverse-round unit and one keyExpansion step.
// Optional AES_DEC_SCHED_ZEROIZE_EN adds a 'zeroize' input that wipes all key and data material.
module aes256_dec_sched #(
    parameter bit SCRUB_STATE = 1'b1,
    parameter int KX_RC_BASE  = 0
) (
    input  logic           clk,
    input  logic           rst,
`ifdef AES_DEC_SCHED_ZEROIZE_EN
    input  logic           zeroize,
`endif
    aes256_dec_sched_if.slave bus,
    output logic           busy,
    output logic [255:0]   kx_key_in,
    output logic [3:0]     kx_rc,
    input  logic [255:0]   kx_key_out,
    output logic [127:0]   rnd_state,
    output logic [127:0]   rnd_key,
    output logic           rnd_last,
    input  logic [127:0]   rnd_result,
    output logic [1:0]     dbg_state
);

    typedef enum logic [1:0] {IDLE = 2'd0, KEXP = 2'd1, RUN = 2'd2, DONE = 2'd3} state_t;

    localparam logic [3:0] RC_BASE = KX_RC_BASE[3:0];

    state_t         state, state_nx;
    logic           key_loaded;
    logic [255:0]   kreg;
    logic [127:0]   st;
    logic [127:0]   rk [15];
    logic [3:0]     round;
    logic [2:0]     step;
    logic [3:0]     rk_even_idx;
    logic [3:0]     rk_odd_idx;
    logic           zero_hit;
    logic           key_fire;
    logic           blk_fire;

`ifdef AES_DEC_SCHED_ZEROIZE_EN
    assign zero_hit = zeroize;
`else
    assign zero_hit = 1'b0;
`endif

    // Step j produces round keys 2j+2 and 2j+3; the last step only has room for rk14.
    assign rk_even_idx = {step, 1'b0} + 4'd2;
    assign rk_odd_idx  = {step, 1'b0} + 4'd3;
    assign key_fire    = bus.key_valid & bus.key_ready;
    assign blk_fire    = bus.in_valid & bus.in_ready;
    assign dbg_state   = state;

    always_ff @(posedge clk) begin
        if (rst || zero_hit) state <= IDLE;
        else                 state <= state_nx;
    end

    always_comb begin
        state_nx     = state;
        bus.key_ready = 1'b0;
        bus.in_ready  = 1'b0;
        busy          = 1'b1;
        kx_key_in     = '0;
        kx_rc         = '0;
        rnd_state     = '0;
        rnd_key       = '0;
        rnd_last      = 1'b0;
        case (state)
            IDLE: begin
                busy          = 1'b0;
                bus.key_ready = 1'b1;
                // A pending key always wins over a pending block.
                bus.in_ready  = key_loaded & ~bus.key_valid;
                if (bus.key_valid)                      state_nx = KEXP;
                else if (bus.in_valid && key_loaded)    state_nx = RUN;
            end
            KEXP: begin
                kx_key_in = kreg;
                kx_rc     = RC_BASE + {1'b0, step};
                if (step == 3'd6) state_nx = IDLE;
            end
            RUN: begin
                rnd_state = st;
                rnd_key   = rk[4'd14 - round];
                rnd_last  = (round == 4'd14);
                if (round == 4'd14) state_nx = DONE;
            end
            DONE: begin
                if (bus.out_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            key_loaded    <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.dout      <= '0;
            round         <= '0;
            step          <= '0;
            st            <= '0;
            kreg          <= '0;
        end else if (zero_hit) begin
            key_loaded    <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.dout      <= '0;
            round         <= '0;
            step          <= '0;
            st            <= '0;
            kreg          <= '0;
            for (int i = 0; i < 15; i++) rk[i] <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (key_fire) begin
                        rk[0]      <= bus.key[255:128];
                        rk[1]      <= bus.key[127:0];
                        kreg       <= bus.key;
                        key_loaded <= 1'b0;
                        step       <= '0;
                    end else if (blk_fire) begin
                        st    <= bus.din ^ rk[14];
                        round <= 4'd1;
                    end
                end
                KEXP: begin
                    rk[rk_even_idx] <= kx_key_out[255:128];
                    if (step != 3'd6) rk[rk_odd_idx] <= kx_key_out[127:0];
                    kreg <= kx_key_out;
                    step <= step + 3'd1;
                    if (step == 3'd6) key_loaded <= 1'b1;
                end
                RUN: begin
                    st    <= rnd_result;
                    round <= round + 4'd1;
                    if (round == 4'd14) begin
                        bus.out_valid <= 1'b1;
                        bus.dout      <= rnd_result;
                        round         <= '0;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        bus.out_valid <= 1'b0;
                        if (SCRUB_STATE) begin
                            st       <= '0;
                            bus.dout <= '0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_aes256_dec_sched.sv
// Bench for aes256_dec_sched: real inverse-round and key-expansion models wired to the datapath
// ports, known-answer and randomised blocks, handshake corner cases, mid-run reset.
module tb_aes256_dec_sched;

  localparam logic [255:0] KEY1   = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [255:0] KEY2   = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
  localparam logic [127:0] KAT_CT = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [127:0] KAT_PT = 128'h00112233445566778899aabbccddeeff;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  aes256_dec_sched_if bus ();
  logic         busy;
  logic [255:0] kx_key_in;
  logic [3:0]   kx_rc;
  logic [255:0] kx_key_out;
  logic [127:0] rnd_state;
  logic [127:0] rnd_key;
  logic         rnd_last;
  logic [127:0] rnd_result;
  logic [1:0]   dbg_state;
`ifdef AES_DEC_SCHED_ZEROIZE_EN
  logic         zeroize;
`endif

  aes256_dec_sched dut (
    .clk        (clk),
    .rst        (rst),
`ifdef AES_DEC_SCHED_ZEROIZE_EN
    .zeroize    (zeroize),
`endif
    .bus        (bus),
    .busy       (busy),
    .kx_key_in  (kx_key_in),
    .kx_rc      (kx_rc),
    .kx_key_out (kx_key_out),
    .rnd_state  (rnd_state),
    .rnd_key    (rnd_key),
    .rnd_last   (rnd_last),
    .rnd_result (rnd_result),
    .dbg_state  (dbg_state)
  );

  // ---------------- AES reference pieces ----------------
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r = 8'h00;
    logic [7:0] p = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) r = r ^ p;
      p = xt(p);
    end
    return r;
  endfunction

  // x^254 = multiplicative inverse in GF(2^8), 0 maps to 0
  function automatic logic [7:0] ginv(input logic [7:0] x);
    logic [7:0] r = 8'h01;
    logic [7:0] p = x;
    for (int i = 0; i < 8; i++) begin
      if (i != 0) r = gmul(r, p);
      p = gmul(p, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] b = ginv(x);
    return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] y);
    return ginv(rotl8(y, 1) ^ rotl8(y, 3) ^ rotl8(y, 6) ^ 8'h05);
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [255:0] kexp_step(input logic [255:0] k, input logic [3:0] rc);
    logic [31:0] w [8];
    logic [31:0] n [8];
    logic [7:0]  rcon = 8'h01;
    for (int i = 0; i < int'(rc); i++) rcon = xt(rcon);
    for (int i = 0; i < 8; i++) w[i] = k[255 - 32*i -: 32];
    n[0] = w[0] ^ sub_word({w[7][23:0], w[7][31:24]}) ^ {rcon, 24'h0};
    for (int i = 1; i < 4; i++) n[i] = w[i] ^ n[i-1];
    n[4] = w[4] ^ sub_word(n[3]);
    for (int i = 5; i < 8; i++) n[i] = w[i] ^ n[i-1];
    return {n[0], n[1], n[2], n[3], n[4], n[5], n[6], n[7]};
  endfunction

  function automatic logic [127:0] inv_shift_sub(input logic [127:0] s);
    logic [127:0] o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127 - 8*(r + 4*c) -: 8] = inv_sbox(s[127 - 8*(r + 4*((c - r + 4) % 4)) -: 8]);
    return o;
  endfunction

  function automatic logic [127:0] inv_mix(input logic [127:0] s);
    logic [127:0] o = '0;
    logic [7:0] a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127 - 32*c -: 8];
      a1 = s[119 - 32*c -: 8];
      a2 = s[111 - 32*c -: 8];
      a3 = s[103 - 32*c -: 8];
      o[127 - 32*c -: 8] = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
      o[119 - 32*c -: 8] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
      o[111 - 32*c -: 8] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
      o[103 - 32*c -: 8] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
    end
    return o;
  endfunction

  function automatic logic [127:0] inv_round(input logic [127:0] s, input logic [127:0] k);
    return inv_mix(inv_shift_sub(s) ^ k);
  endfunction

  function automatic logic [127:0] inv_last(input logic [127:0] s, input logic [127:0] k);
    return inv_shift_sub(s) ^ k;
  endfunction

  function automatic logic [127:0] ref_decrypt(input logic [255:0] k, input logic [127:0] ct);
    logic [127:0] rks [15];
    logic [255:0] kr = k;
    logic [127:0] s;
    rks[0] = k[255:128];
    rks[1] = k[127:0];
    for (int j = 0; j < 7; j++) begin
      kr = kexp_step(kr, 4'(j));
      rks[2*j + 2] = kr[255:128];
      if (j < 6) rks[2*j + 3] = kr[127:0];
    end
    s = ct ^ rks[14];
    for (int r = 1; r < 14; r++) s = inv_round(s, rks[14 - r]);
    return inv_last(s, rks[0]);
  endfunction

  // external combinational units
  assign kx_key_out = kexp_step(kx_key_in, kx_rc);
  assign rnd_result = rnd_last ? inv_last(rnd_state, rnd_key) : inv_round(rnd_state, rnd_key);

  // ---------------- scoreboard / checking ----------------
  logic [127:0] exp_q [$];
  int n_checks = 0;
  int n_pass   = 0;
  int n_out    = 0;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      n_out++;
      check("sb_has_expected", 256'(exp_q.size() != 0), 256'(1));
      if (exp_q.size() != 0) check("dout", 256'(bus.dout), 256'(exp_q.pop_front()));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic load_key(input logic [255:0] k);
    int n;
    bus.key = k;
    bus.key_valid = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.key_ready && n < 100);
    @(posedge clk); #1;
    bus.key_valid = 1'b0;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!busy) break;
      n++;
    end
    check("key_busy_cycles", 256'(n), 256'(7));
    @(posedge clk); #1;
  endtask

  task automatic send_block(input logic [127:0] ct, input logic [127:0] exp, output int n_wait);
    int n;
    exp_q.push_back(exp);
    bus.din = ct;
    bus.in_valid = 1'b1;
    n_wait = 0;
    do begin @(negedge clk); n_wait++; end while (!bus.in_ready && n_wait < 100);
    check("in_accept", 256'(bus.in_ready), 256'(1));
    if (!bus.in_ready) begin
      bus.in_valid = 1'b0;
      void'(exp_q.pop_back());
      return;
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.out_valid && n < 40);
    check("out_latency", 256'(n), 256'(15));
    @(posedge clk); #1;
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout");
    $fatal(1, "bench timeout");
  end

  // ---------------- main sequence ----------------
  initial begin
    int nw;
    int base_out;
    logic flag;
    logic [127:0] ct;
    logic [127:0] held;

    rst = 1'b1;
    bus.key = '0;
    bus.key_valid = 1'b0;
    bus.din = '0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
`ifdef AES_DEC_SCHED_ZEROIZE_EN
    zeroize = 1'b0;
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 256'(busy), 256'(0));
    check("rst_out_valid", 256'(bus.out_valid), 256'(0));
    check("rst_dout", 256'(bus.dout), 256'(0));
    check("rst_kx_rc", 256'(kx_rc), 256'(0));
    check("rst_key_ready", 256'(bus.key_ready), 256'(1));
    @(posedge clk); #1;
    rst = 1'b0;

    // block offered with no key loaded
    bus.din = KAT_CT;
    bus.in_valid = 1'b1;
    flag = 1'b0;
    repeat (30) begin @(negedge clk); if (bus.in_ready || busy) flag = 1'b1; end
    check("nokey_never_ready", 256'(flag), 256'(0));
    @(posedge clk); #1;
    bus.in_valid = 1'b0;

    // known answer
    load_key(KEY1);
    send_block(KAT_CT, KAT_PT, nw);
    check("kat_in_wait", 256'(nw), 256'(1));

    // random blocks with random gaps
    for (int i = 0; i < 4; i++) begin
      ct = {$urandom, $urandom, $urandom, $urandom};
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      send_block(ct, ref_decrypt(KEY1, ct), nw);
    end

    // key and block offered together: key first, block after expansion
    ct = {$urandom, $urandom, $urandom, $urandom};
    bus.key = KEY2;
    bus.key_valid = 1'b1;
    bus.din = ct;
    bus.in_valid = 1'b1;
    @(negedge clk);
    check("tie_in_ready", 256'(bus.in_ready), 256'(0));
    check("tie_key_ready", 256'(bus.key_ready), 256'(1));
    @(posedge clk); #1;
    bus.key_valid = 1'b0;
    send_block(ct, ref_decrypt(KEY2, ct), nw);
    check("tie_block_wait", 256'(nw), 256'(8));

    // backpressure in DONE
    bus.out_ready = 1'b0;
    ct = {$urandom, $urandom, $urandom, $urandom};
    send_block(ct, ref_decrypt(KEY2, ct), nw);
    held = bus.dout;
    bus.din = {$urandom, $urandom, $urandom, $urandom};
    bus.in_valid = 1'b1;
    flag = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (!bus.out_valid || bus.dout !== held || bus.in_ready || !busy) flag = 1'b1;
    end
    check("hold_stable", 256'(flag), 256'(0));
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    base_out = n_out;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("post_hs_out_valid", 256'(bus.out_valid), 256'(0));
    check("post_hs_scrub_dout", 256'(bus.dout), 256'(0));
    repeat (5) @(negedge clk);
    check("one_handshake", 256'(n_out - base_out), 256'(1));
    @(posedge clk); #1;

    // reset during round 7
    load_key(KEY1);
    bus.din = KAT_CT;
    bus.in_valid = 1'b1;
    @(negedge clk);
    check("abort_accept", 256'(bus.in_ready), 256'(1));
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check("abort_in_run", 256'(dbg_state), 256'(2));
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("abort_busy", 256'(busy), 256'(0));
    check("abort_out_valid", 256'(bus.out_valid), 256'(0));
    @(posedge clk); #1;
    bus.in_valid = 1'b1;
    flag = 1'b0;
    repeat (10) begin @(negedge clk); if (bus.in_ready || bus.out_valid) flag = 1'b1; end
    check("abort_needs_key", 256'(flag), 256'(0));
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    load_key(KEY1);
    send_block(KAT_CT, KAT_PT, nw);

`ifdef AES_DEC_SCHED_ZEROIZE_EN
    // zeroize while holding a result
    bus.out_ready = 1'b0;
    ct = {$urandom, $urandom, $urandom, $urandom};
    send_block(ct, ref_decrypt(KEY1, ct), nw);
    zeroize = 1'b1;
    @(posedge clk); #1;
    zeroize = 1'b0;
    @(negedge clk);
    check("zero_out_valid", 256'(bus.out_valid), 256'(0));
    check("zero_dout", 256'(bus.dout), 256'(0));
    check("zero_busy", 256'(busy), 256'(0));
    if (exp_q.size() != 0) void'(exp_q.pop_back());
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b1;
    flag = 1'b0;
    repeat (5) begin @(negedge clk); if (bus.in_ready) flag = 1'b1; end
    check("zero_needs_key", 256'(flag), 256'(0));
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
`endif

    repeat (5) @(negedge clk);
    check("sb_drained", 256'(exp_q.size()), 256'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
